// File: rtl/msrv_32_dmem_responder.sv
// Byte-maskable word memory on the msrv_32 data port, with programmable wait states and read-after-write forwarding.
// Optional: define MSRV32_DMEM_MASK_CHK_EN to reject illegal write masks with an error response.
module msrv_32_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmadder_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [1:0]  ahb_htrans_in,
  output logic [31:0] ms_riscv32_mp_dmdata_out,
  output logic        ahb_ready_out,
  output logic        ahb_resp_out
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t           state;
  logic [2:0]       wait_cnt;
  logic [IDX_W-1:0] cap_idx_p1;
  logic             cap_wr_p1;
  logic [3:0]       cap_mask_p1;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] req_idx;
  logic             req_oor;
  logic             req_bad;
  logic             accept;
  logic             commit;
  logic [31:0]      fwd_word;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++)
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    return res;
  endfunction

`ifdef MSRV32_DMEM_MASK_CHK_EN
  function automatic logic mask_legal(input logic [3:0] m);
    case (m)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction
`endif

  assign req_idx = IDX_W'(ms_riscv32_mp_dmadder_in >> 2);
  assign req_oor = (ms_riscv32_mp_dmadder_in >> 2) >= 32'(DEPTH_WORDS);
`ifdef MSRV32_DMEM_MASK_CHK_EN
  assign req_bad = req_oor ||
                   (ms_riscv32_mp_dmwr_req_in && !mask_legal(ms_riscv32_mp_dmwr_mask_in));
`else
  assign req_bad = req_oor;
`endif
  assign accept = ahb_ready_out && ahb_htrans_in[1];
  assign commit = (state == S_DATA) && cap_wr_p1;

  // A read whose data phase starts on the edge that commits a write to the same word sees the merged word.
  assign fwd_word = merge_bytes(mem[req_idx], ms_riscv32_mp_dmdata_in,
                                (commit && (cap_idx_p1 == req_idx)) ? cap_mask_p1 : 4'b0000);

  // Address phase -> data phase capture
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (accept) begin
      cap_idx_p1  <= req_idx;
      cap_wr_p1   <= ms_riscv32_mp_dmwr_req_in;
      cap_mask_p1 <= ms_riscv32_mp_dmwr_mask_in;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (commit)
      mem[cap_idx_p1] <= merge_bytes(mem[cap_idx_p1], ms_riscv32_mp_dmdata_in, cap_mask_p1);
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state                    <= S_IDLE;
      wait_cnt                 <= '0;
      ahb_ready_out            <= 1'b1;
      ahb_resp_out             <= 1'b0;
      ms_riscv32_mp_dmdata_out <= '0;
    end else begin
      ahb_ready_out            <= 1'b1;
      ahb_resp_out             <= 1'b0;
      ms_riscv32_mp_dmdata_out <= '0;
      case (state)
        S_WAIT: begin
          if (wait_cnt == 3'(WAIT_STATES)) begin
            state    <= S_DATA;
            wait_cnt <= '0;
            if (!cap_wr_p1) ms_riscv32_mp_dmdata_out <= mem[cap_idx_p1];
          end else begin
            wait_cnt      <= wait_cnt + 3'd1;
            ahb_ready_out <= 1'b0;
          end
        end
        S_ERR1: begin
          state        <= S_ERR2;
          ahb_resp_out <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all present ready=1 and may accept the next address phase.
          if (accept) begin
            if (req_bad) begin
              state         <= S_ERR1;
              ahb_ready_out <= 1'b0;
              ahb_resp_out  <= 1'b1;
            end else if (WAIT_STATES > 0) begin
              state         <= S_WAIT;
              wait_cnt      <= 3'd1;
              ahb_ready_out <= 1'b0;
            end else begin
              state <= S_DATA;
              if (!ms_riscv32_mp_dmwr_req_in) ms_riscv32_mp_dmdata_out <= fwd_word;
            end
          end else begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/msrv_32_dmem_responder.md
Name: msrv_32_dmem_responder

Overview:
- Data-memory responder for the msrv_32 core's AHB-lite-style data port.
- Sits on the memory side of the core's store path. It consumes the word-aligned address, the byte write mask, the write request, write data and the HTRANS the core drives.
- Returns HREADY, an error response and read data.
- Implements a byte-maskable word memory with programmable wait states and read-after-write forwarding.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; legal addresses are 0 to 4*DEPTH_WORDS-4.
- WAIT_STATES, 1: extra data-phase cycles with ready low per transfer; legal range 0..7.

Ports:
- ms_riscv32_mp_clk_in  input  1  system clock, rising edge.
- ms_riscv32_mp_rst_in  input  1  asynchronous, active-low reset.
- ms_riscv32_mp_dmadder_in  input  32  transfer address; bits [1:0] are ignored (treated as 0).
- ms_riscv32_mp_dmdata_in  input  32  write data, sampled in the data phase.
- ms_riscv32_mp_dmwr_mask_in  input  4  byte write-enable mask, sampled in the address phase.
- ms_riscv32_mp_dmwr_req_in  input  1  1 = write, 0 = read; sampled in the address phase.
- ahb_htrans_in  input  2  2'b10/2'b11 = active transfer; 2'b00/2'b01 = no transfer.
- ms_riscv32_mp_dmdata_out  output  32  read data; valid only in the final data-phase cycle of a read.
- ahb_ready_out  output  1  HREADY.
- ahb_resp_out  output  1  HRESP; 1 = error.

Behaviour:
- Reset (asynchronous, active low):
  - ahb_ready_out=1, ahb_resp_out=0, dmdata_out=0.
  - FSM goes to IDLE; wait counter=0; forwarding buffer invalid.
  - Memory array is not cleared.
  - A transfer in flight when reset asserts is discarded; a pending write is not committed.
- Address phase: an address phase is accepted on a rising edge where ahb_ready_out=1 and htrans[1]=1. On acceptance the block captures address word index, wr_req, mask and an out-of-range flag (index >= DEPTH_WORDS).
- FSM states:
  - IDLE: ready=1. On acceptance, go to ERR1 if out of range. Otherwise go to WAIT if WAIT_STATES>0, else DATA.
  - WAIT: ready=0; counter counts 1..WAIT_STATES; go to DATA after WAIT_STATES cycles.
  - DATA: ready=1; final data-phase cycle.
    - Write: the edge ending DATA commits bytes of dmdata_in selected by the captured mask. Mask 0 means no byte changes.
    - Read: dmdata_out = word at captured index.
    - A new address phase accepted in the same cycle (pipelining) goes to WAIT, DATA or ERR1; otherwise go to IDLE.
  - ERR1: ready=0, resp=1. Go to ERR2.
  - ERR2: ready=1, resp=1; no memory change; dmdata_out=0. An address phase may be accepted in this cycle (it is not cancelled); same next-state rules as DATA.
- With WAIT_STATES=0, back-to-back transfers complete one per cycle with ready held at 1.
- Read-after-write forwarding:
  - Applies when a read's data phase directly follows a write's data phase to the same index.
  - The returned word is the pre-write memory word with masked bytes replaced by the committed write bytes.
  - Required for all WAIT_STATES values.
- dmdata_out=0 in every cycle other than a read's DATA cycle.
- ahb_resp_out=0 outside ERR1/ERR2.
- htrans 2'b00/2'b01 in an accepted slot: no transfer, FSM stays or returns to IDLE, OKAY response.
- Address bits [31:2] are used for the range check; there is no wrap-around.

Optional Feature:
- Macro: MSRV32_DMEM_MASK_CHK_EN.
- Defined: the write mask is checked in the address phase of writes. Legal masks are 0001, 0010, 0100, 1000, 0011, 1100, 1111 and 0000. Any other mask takes the ERR1/ERR2 path and the write is suppressed.
- Undefined: no mask check; any mask is committed bytewise.

Test Plan:
- Reset: assert rst low mid-WAIT of a write to 0x10 with data 0xAABBCCDD -> ready=1, resp=0, dmdata_out=0 immediately; a later read of 0x10 returns the prior contents unchanged.
- WAIT_STATES=2: write 0x20 data 0x12345678 mask 1111, then read 0x20 -> each transfer shows ready low for 2 cycles then high 1 cycle; the read returns 0x12345678.
- WAIT_STATES=0: back-to-back write 0x40 mask 0010 data 0x0000AB00 over old word 0x11223344, then read 0x40 -> read returns 0x1122AB44 in the next cycle (forwarding); ready never low.
- Out of range: read address 4*DEPTH_WORDS (0x1000) -> cycle 1 ready=0/resp=1, cycle 2 ready=1/resp=1, dmdata_out=0; no memory change.
- Idle and no-write: htrans=00 with wr_req=1 -> no write, resp=0. Write with mask 0000 to 0x8 -> word unchanged.
- MSRV32_DMEM_MASK_CHK_EN defined: write 0x30 mask 0101 -> two-cycle error, word 0x30 unchanged. Macro undefined: the same write updates bytes 0 and 2.
